// File: rtl/rr_arbiter8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int unsigned c_nreqs   = 8;
    localparam int unsigned c_selbits = 3;

endpackage

// File: rtl/rr_arbiter8_if.sv
// Requester-side and downstream val/rdy handshake bundle for rr_arbiter8.
interface rr_arbiter8_if
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned p_nbits = 32
);

    logic [c_nreqs-1:0]         req_val;
    logic [c_nreqs-1:0]         req_rdy;
    logic [c_nreqs*p_nbits-1:0] req_msg;
    logic                       resp_val;
    logic                       resp_rdy;
    logic [p_nbits-1:0]         resp_msg;
    logic [c_selbits-1:0]       resp_src;

    modport master (
        output req_val, req_msg, resp_rdy,
        input  req_rdy, resp_val, resp_msg, resp_src
    );

    modport slave (
        input  req_val, req_msg, resp_rdy,
        output req_rdy, resp_val, resp_msg, resp_src
    );

endinterface

// File: rtl/rr_arbiter8_priority_sel8.sv
// Rotating priority selector (winner search starting at ptr) and the
// 8-input message mux used to steer the winner's payload.
module rr_priority_sel8
    import rr_arbiter8_pkg::*;
(
    input  logic [c_nreqs-1:0]   req_val,
    input  logic [c_selbits-1:0] ptr,
    output logic [c_selbits-1:0] gsel,
    output logic                 any
);

    logic [2*c_nreqs-1:0] dbl;
    logic [c_nreqs-1:0]   rot;
    logic [c_selbits-1:0] idx;
    logic                 found;

    // Rotating right by ptr puts requester ptr at bit 0, so the lowest set
    // bit is the winner's distance from ptr.
    always_comb begin
        dbl   = {req_val, req_val} >> ptr;
        rot   = dbl[c_nreqs-1:0];
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < c_nreqs; i++) begin
            if (rot[i] && !found) begin
                idx   = i[c_selbits-1:0];
                found = 1'b1;
            end
        end
        any  = |req_val;
        gsel = ptr + idx;
    end

endmodule

module mux8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned p_nbits = 32
) (
    input  logic [c_nreqs*p_nbits-1:0] in_flat,
    input  logic [c_selbits-1:0]       sel,
    output logic [p_nbits-1:0]         out
);

    always_comb begin
        out = '0;
        for (int unsigned i = 0; i < c_nreqs; i++) begin
            if (sel == i[c_selbits-1:0]) begin
                out = in_flat[i*p_nbits +: p_nbits];
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: eight val/rdy requesters share one registered
// single-entry output buffer; the last winner drops to lowest priority.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned p_nbits = 32
) (
    input  logic          clk,
    input  logic          reset,
    rr_arbiter8_if.slave  bus
);

    state_t               state_q, state_d;
    logic [c_selbits-1:0] ptr_q,   ptr_d;
    logic [p_nbits-1:0]   msg_q,   msg_d;
    logic [c_selbits-1:0] src_q,   src_d;

    logic [c_selbits-1:0] gsel;
    logic                 any;
    logic [p_nbits-1:0]   sel_msg;
    logic                 can_acc;
    logic                 xfer;

    rr_priority_sel8 u_sel (
        .req_val (bus.req_val),
        .ptr     (ptr_q),
        .gsel    (gsel),
        .any     (any)
    );

    mux8 #(
        .p_nbits (p_nbits)
    ) u_mux (
        .in_flat (bus.req_msg),
        .sel     (gsel),
        .out     (sel_msg)
    );

    // A FULL buffer being drained this cycle can refill in the same cycle.
    always_comb begin
        can_acc  = (state_q == EMPTY) | bus.resp_rdy;
        xfer     = any & can_acc & ~reset;
        state_d  = state_q;
        ptr_d    = ptr_q;
        msg_d    = msg_q;
        src_d    = src_q;
        if (xfer) begin
            state_d = FULL;
            msg_d   = sel_msg;
            src_d   = gsel;
            ptr_d   = gsel + 3'd1;
        end else if ((state_q == FULL) && bus.resp_rdy) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            msg_q   <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            msg_q   <= msg_d;
            src_q   <= src_d;
        end
    end

    assign bus.req_rdy  = xfer ? (8'b1 << gsel) : '0;
    assign bus.resp_val = (state_q == FULL);
    assign bus.resp_msg = msg_q;
    assign bus.resp_src = src_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: a reference round-robin model predicts
// grants and pushes expected buffer contents, popped as the buffer drains.
module tb_rr_arbiter8;

    typedef struct {
        logic [31:0] msg;
        logic [2:0]  src;
    } sb_t;

    logic clk;
    logic reset;
    logic [7:0][31:0] msgs;

    rr_arbiter8_if #(.p_nbits(32)) bus ();

    rr_arbiter8 #(.p_nbits(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.req_msg = msgs;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic       m_full;
    logic [2:0] m_ptr;
    sb_t        sb[$];

    function automatic logic [2:0] m_gsel(input logic [7:0] v, input logic [2:0] p);
        logic [2:0] idx;
        for (int k = 0; k < 8; k++) begin
            idx = p + k[2:0];
            if (v[idx]) return idx;
        end
        return 3'd0;
    endfunction

    // One cycle: drive inputs, sample req_rdy mid-cycle, advance model, clock.
    task automatic step(input logic [7:0] v, input logic r,
                        output logic [7:0] obs_rdy, output logic [7:0] exp_rdy);
        logic       acc;
        logic [2:0] g;
        sb_t        e;
        bus.req_val  = v;
        bus.resp_rdy = r;
        #1;
        g       = m_gsel(v, m_ptr);
        acc     = (!m_full || r) && (v != 8'h00);
        exp_rdy = acc ? (8'b1 << g) : 8'h00;
        obs_rdy = bus.req_rdy;
        if (m_full && r && sb.size() > 0) void'(sb.pop_front());
        if (acc) begin
            e.msg = msgs[g];
            e.src = g;
            sb.push_back(e);
            m_full = 1'b1;
            m_ptr  = g + 3'd1;
        end else if (m_full && r) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [7:0] v);
        reset        = 1'b1;
        bus.req_val  = v;
        bus.resp_rdy = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        m_full = 1'b0;
        m_ptr  = 3'd0;
        sb.delete();
    endtask

    task automatic test_reset();
        apply_reset(8'hFF);
        for (int c = 0; c < 3; c++) begin
            bus.req_val  = 8'h00;
            bus.resp_rdy = 1'b0;
            #1;
            checks++;
            if (bus.req_rdy !== 8'h00 || bus.resp_val !== 1'b0 || bus.resp_src !== 3'd0 || bus.resp_msg !== 32'h0) begin
                errors++;
                $display("FAIL reset_idle: rdy=%h val=%b src=%0d msg=%h, required rdy=00 val=0 src=0 msg=0",
                         bus.req_rdy, bus.resp_val, bus.resp_src, bus.resp_msg);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_single();
        logic [7:0] o, e;
        msgs    = '0;
        msgs[3] = 32'hDEADBEEF;
        step(8'h08, 1'b1, o, e);
        checks++;
        if (o !== 8'h08) begin
            errors++;
            $display("FAIL single_rdy: got %h required 08", o);
        end
        checks++;
        if (bus.resp_val !== 1'b1 || bus.resp_msg !== 32'hDEADBEEF || bus.resp_src !== 3'd3) begin
            errors++;
            $display("FAIL single_resp: val=%b msg=%h src=%0d, required 1 DEADBEEF 3",
                     bus.resp_val, bus.resp_msg, bus.resp_src);
        end
        step(8'h00, 1'b1, o, e);
        checks++;
        if (bus.resp_val !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: resp_val=%b required 0", bus.resp_val);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] o, e;
        apply_reset(8'h00);
        for (int i = 0; i < 8; i++) msgs[i] = i;
        for (int k = 0; k < 9; k++) begin
            step(8'hFF, 1'b1, o, e);
            checks++;
            if (o !== (8'b1 << (k % 8)) || o !== e) begin
                errors++;
                $display("FAIL rotation_rdy[%0d]: got %h required %h", k, o, 8'b1 << (k % 8));
            end
            checks++;
            if (bus.resp_src !== sb[0].src || bus.resp_msg !== {29'd0, bus.resp_src}) begin
                errors++;
                $display("FAIL rotation_resp[%0d]: src=%0d msg=%h required src=%0d msg=src",
                         k, bus.resp_src, bus.resp_msg, sb[0].src);
            end
        end
        step(8'h00, 1'b1, o, e);
    endtask

    task automatic test_wrap();
        logic [7:0] o, e;
        apply_reset(8'h00);
        step(8'h40, 1'b1, o, e);
        step(8'h81, 1'b1, o, e);
        checks++;
        if (o !== 8'h80) begin
            errors++;
            $display("FAIL wrap_first: got %h required 80", o);
        end
        step(8'h81, 1'b1, o, e);
        checks++;
        if (o !== 8'h01) begin
            errors++;
            $display("FAIL wrap_second: got %h required 01", o);
        end
        step(8'h00, 1'b1, o, e);
    endtask

    task automatic test_back_pressure();
        logic [7:0] o, e;
        apply_reset(8'h00);
        msgs[2] = 32'hCAFE0002;
        msgs[4] = 32'hCAFE0004;
        msgs[5] = 32'hCAFE0005;
        step(8'h04, 1'b1, o, e);
        for (int c = 0; c < 4; c++) begin
            step(8'h30, 1'b0, o, e);
            checks++;
            if (o !== 8'h00 || bus.resp_val !== 1'b1 || bus.resp_src !== 3'd2 || bus.resp_msg !== 32'hCAFE0002) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: rdy=%h val=%b src=%0d msg=%h required 00 1 2 CAFE0002",
                         c, o, bus.resp_val, bus.resp_src, bus.resp_msg);
            end
        end
        step(8'h30, 1'b1, o, e);
        checks++;
        if (o !== 8'h10 || bus.resp_src !== 3'd4 || bus.resp_msg !== 32'hCAFE0004) begin
            errors++;
            $display("FAIL backpressure_release: rdy=%h src=%0d msg=%h required 10 4 CAFE0004",
                     o, bus.resp_src, bus.resp_msg);
        end
        step(8'h00, 1'b1, o, e);
    endtask

    task automatic test_reset_mid();
        logic [7:0] o, e;
        step(8'h20, 1'b1, o, e);
        checks++;
        if (bus.resp_val !== 1'b1 || bus.resp_src !== 3'd5) begin
            errors++;
            $display("FAIL midreset_setup: val=%b src=%0d required 1 5", bus.resp_val, bus.resp_src);
        end
        reset        = 1'b1;
        bus.req_val  = 8'hFF;
        bus.resp_rdy = 1'b1;
        #1;
        checks++;
        if (bus.req_rdy !== 8'h00) begin
            errors++;
            $display("FAIL midreset_rdy: got %h required 00", bus.req_rdy);
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        m_full = 1'b0;
        m_ptr  = 3'd0;
        sb.delete();
        bus.req_val = 8'h00;
        #1;
        checks++;
        if (bus.resp_val !== 1'b0) begin
            errors++;
            $display("FAIL midreset_val: got %b required 0", bus.resp_val);
        end
        step(8'hFF, 1'b1, o, e);
        checks++;
        if (o !== 8'h01) begin
            errors++;
            $display("FAIL midreset_first: got %h required 01", o);
        end
        step(8'h00, 1'b1, o, e);
    endtask

    task automatic test_random();
        logic [7:0] o, e, v;
        logic       r;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 8; i++) msgs[i] = $urandom;
            v = (c % 7 == 0) ? 8'h00 : 8'($urandom);
            r = ($urandom_range(0, 3) != 0);
            step(v, r, o, e);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL random_rdy[%0d]: got %h required %h", c, o, e);
            end
            checks++;
            if (bus.resp_val !== m_full) begin
                errors++;
                $display("FAIL random_val[%0d]: got %b required %b", c, bus.resp_val, m_full);
            end else if (m_full) begin
                checks++;
                if (bus.resp_msg !== sb[0].msg || bus.resp_src !== sb[0].src) begin
                    errors++;
                    $display("FAIL random_resp[%0d]: msg=%h src=%0d required msg=%h src=%0d",
                             c, bus.resp_msg, bus.resp_src, sb[0].msg, sb[0].src);
                end
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        msgs         = '0;
        bus.req_val  = 8'h00;
        bus.resp_rdy = 1'b0;
        m_full       = 1'b0;
        m_ptr        = 3'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
